secuenciador_teclado: RTL and testbench
=======================================

// Module: secuenciador_teclado
// PURPOSE
//  Keypad sequencer in front of the parking gate Controlador. Collects BCD digits one key
//  at a time, assembles the 16-bit Clave, issues a single-cycle Enter, then waits for
//  the controller's verdict (Abrir / AlrmInt / AlrmCom) before accepting a new attempt.
//  Sits between the keypad scanner and Controlador; owns the Clave/Enter pins.
// PARAMETERS
//  N_DIG      4     digits per password (Clave width = 4*N_DIG)
//  T_INACT    1000  idle cycles after last digit before partial entry is discarded
//  T_RESP     16    cycles to wait for controller verdict after Enter
// PORTS
//  Clk        in   1        system clock, rising edge
//  Reset      in   1        asynchronous, active-low reset
//  Tecla      in   4        BCD digit from keypad, sampled when TeclaVal=1
//  TeclaVal   in   1        one-cycle strobe: digit key pressed
//  TeclaEnt   in   1        one-cycle strobe: enter key pressed
//  TeclaBorr  in   1        one-cycle strobe: clear key pressed
//  Abrir      in   1        from Controlador: password accepted
//  AlrmInt    in   1        from Controlador: wrong password
//  AlrmCom    in   1        from Controlador: gate/block alarm
//  Clave      out  16       assembled password to Controlador, first digit in [15:12]
//  Enter      out  1        one-cycle strobe to Controlador
//  Digitos    out  3        digits captured so far (0..N_DIG)
//  Rechazo    out  1        one-cycle pulse: key rejected / entry discarded
//  Ocupado    out  1        1 while awaiting verdict or blocked; keys ignored
// BEHAVIOUR
//  Reset (Reset=0): state IDLE, Clave=0, Enter=0, Digitos=0, Rechazo=0, Ocupado=0, timers 0.
//  Key priority per cycle: TeclaBorr > TeclaEnt > TeclaVal; lower-priority strobes dropped.
//  States:
//   IDLE   : TeclaVal & Tecla<=9 -> Clave<={Clave[11:0],Tecla}, Digitos=1, ->CAPT.
//            TeclaEnt -> Rechazo pulse, stay. Tecla>9 -> Rechazo, stay.
//   CAPT   : valid digit shifts in, Digitos++; Digitos==N_DIG -> further digits Rechazo.
//            Tecla>9 -> Rechazo, no shift. TeclaBorr -> Clave=0, Digitos=0, ->IDLE.
//            TeclaEnt & Digitos==N_DIG -> ->ENVIO; TeclaEnt & Digitos<N_DIG -> Rechazo,
//            clear, ->IDLE. Inactivity counter reloads on every accepted key; reaching
//            T_INACT -> Rechazo, clear, ->IDLE.
//   ENVIO  : Enter=1 for exactly one cycle, Clave stable, Ocupado=1, ->ESPERA.
//   ESPERA : Ocupado=1, Clave held. Abrir or AlrmInt -> clear, ->IDLE next cycle.
//            No verdict within T_RESP cycles -> Rechazo, clear, ->IDLE.
//   BLOQ   : entered from any state when AlrmCom=1 (overrides all); Ocupado=1, Clave=0,
//            Digitos=0, keys ignored; AlrmCom=0 -> IDLE.
//  Latency: Enter asserted the cycle after the accepted TeclaEnt registers.
//  Outputs registered; Rechazo and Enter never high in same cycle; Digitos saturates at N_DIG.
//  Abrir/AlrmInt outside ESPERA ignored. Simultaneous Abrir & AlrmInt: treated as verdict.
//  Reset asserted mid-attempt (incl. during Enter) aborts immediately to reset values.
// STRUCTURE
//  Shared package: state encoding (IDLE,CAPT,ENVIO,ESPERA,BLOQ), BCD_MAX=9, N_DIG default.
//  One sub-module natural: contador_timeout (loadable down-counter, shared by T_INACT and
//  T_RESP, reload/expire ports). FSM, shift register and Digitos counter stay in top.
// TESTING
//  Reset=0 mid-CAPT -> all outputs 0 next edge, state IDLE, Clave=0.
//  Keys 0,2,5,9 then Ent -> Clave=16'h0259, Enter 1 cycle, Ocupado=1; Abrir -> Digitos=0.
//  Keys 0,2,5 then Ent -> Rechazo 1 cycle, no Enter, Clave=0, Digitos=0.
//  Keys 1,A,2 -> Rechazo on A, Clave=16'h0012, Digitos=2; Borr -> Clave=0.
//  Keys 1,2 then T_INACT idle cycles -> Rechazo, Digitos=0; Enter, ESPERA w/o verdict
//   T_RESP cycles -> Rechazo, back to IDLE.
//  AlrmCom=1 during CAPT -> Ocupado=1, Clave=0, keys ignored; AlrmCom=0 -> IDLE accepts keys.

Source files
------------

// File: rtl/secuenciador_teclado_pkg.sv
// Shared definitions for the keypad sequencer in front of the gate controller.
// Holds the sequencer state encoding, the BCD limit, default timing values,
// and small helpers used by the top-level FSM.
package secuenciador_teclado_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CAPT   = 3'd1,
        ST_ENVIO  = 3'd2,
        ST_ESPERA = 3'd3,
        ST_BLOQ   = 3'd4
    } estado_t;

    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam int         N_DIG_DEF   = 4;
    localparam int         T_INACT_DEF = 1000;
    localparam int         T_RESP_DEF  = 16;

    // A keypad code is a usable digit only in the BCD range 0..9.
    function automatic logic es_bcd(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

    // States in which the keypad is locked out (verdict pending or alarm).
    function automatic logic estado_ocupado(input estado_t s);
        logic r;
        case (s)
            ST_ENVIO:  r = 1'b1;
            ST_ESPERA: r = 1'b1;
            ST_BLOQ:   r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/secuenciador_teclado_contador_timeout.sv
// Loadable down-counter shared by the inactivity and verdict timeouts.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   cargar     : load 'valor' this cycle (has priority over decrementing)
//   valor      : reload value (cycles remaining minus one)
//   decr       : decrement by one, saturating at zero
//   expirado   : count has reached zero
module contador_timeout #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cargar,
    input  logic [W-1:0] valor,
    input  logic         decr,
    output logic         expirado
);

    logic [W-1:0] cuenta_r;

    // Count register: load wins, otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_r <= {W{1'b0}};
        end else if (cargar) begin
            cuenta_r <= valor;
        end else if (decr && (cuenta_r != {W{1'b0}})) begin
            cuenta_r <= cuenta_r - W'(1);
        end else begin
            cuenta_r <= cuenta_r;
        end
    end

    assign expirado = (cuenta_r == {W{1'b0}});

endmodule

// File: rtl/secuenciador_teclado.sv
// Keypad sequencer: collects BCD digits, assembles the password, issues a
// one-cycle Enter to the gate controller and waits for its verdict.
// Ports:
//   Clk, Reset            : clock, asynchronous active-low reset
//   Tecla/TeclaVal        : digit code and its one-cycle strobe
//   TeclaEnt, TeclaBorr   : enter / clear key strobes
//   Abrir, AlrmInt        : controller verdict (accepted / wrong password)
//   AlrmCom               : controller alarm, forces the blocked state
//   Clave                 : assembled password, first digit in the top nibble
//   Enter                 : one-cycle strobe to the controller
//   Digitos               : number of digits captured so far
//   Rechazo               : one-cycle pulse when a key or entry is rejected
//   Ocupado               : keypad locked (verdict pending or alarm)
module secuenciador_teclado
    import secuenciador_teclado_pkg::*;
#(
    parameter int N_DIG   = N_DIG_DEF,
    parameter int T_INACT = T_INACT_DEF,
    parameter int T_RESP  = T_RESP_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [3:0]         Tecla,
    input  logic               TeclaVal,
    input  logic               TeclaEnt,
    input  logic               TeclaBorr,
    input  logic               Abrir,
    input  logic               AlrmInt,
    input  logic               AlrmCom,
    output logic [4*N_DIG-1:0] Clave,
    output logic               Enter,
    output logic [2:0]         Digitos,
    output logic               Rechazo,
    output logic               Ocupado
);

    localparam int CW    = 4 * N_DIG;
    localparam int T_MAX = (T_INACT > T_RESP) ? T_INACT : T_RESP;
    localparam int TW    = $clog2(T_MAX + 1);
    // Timer is loaded with N-1 so that expiry is seen on the N-th idle cycle.
    localparam logic [TW-1:0] CARGA_INACT = TW'(T_INACT - 1);
    localparam logic [TW-1:0] CARGA_RESP  = TW'(T_RESP - 1);
    localparam logic [2:0]    DIG_LLENO   = 3'(N_DIG);

    estado_t         estado_r,  estado_s;
    logic [CW-1:0]   clave_r,   clave_s;
    logic [2:0]      digitos_r, digitos_s;
    logic            enter_r,   enter_s;
    logic            rechazo_r, rechazo_s;
    logic            ocupado_r, ocupado_s;
    logic            tmr_cargar_s;
    logic            tmr_decr_s;
    logic [TW-1:0]   tmr_valor_s;
    logic            tmr_exp_s;
    logic            digito_ok_s;

    assign digito_ok_s = TeclaVal & es_bcd(Tecla);

    contador_timeout #(
        .W (TW)
    ) u_timeout (
        .clk      (Clk),
        .rst_n    (Reset),
        .cargar   (tmr_cargar_s),
        .valor    (tmr_valor_s),
        .decr     (tmr_decr_s),
        .expirado (tmr_exp_s)
    );

    // Next-state, datapath and output decode; the alarm overrides everything.
    always_comb begin
        estado_s     = estado_r;
        clave_s      = clave_r;
        digitos_s    = digitos_r;
        enter_s      = 1'b0;
        rechazo_s    = 1'b0;
        tmr_cargar_s = 1'b0;
        tmr_decr_s   = 1'b0;
        tmr_valor_s  = CARGA_INACT;

        if (AlrmCom) begin
            estado_s  = ST_BLOQ;
            clave_s   = {CW{1'b0}};
            digitos_s = 3'd0;
        end else begin
            case (estado_r)
                ST_IDLE: begin
                    // Clear is a no-op here; Enter with nothing typed is refused.
                    if (TeclaBorr) begin
                        estado_s = ST_IDLE;
                    end else if (TeclaEnt) begin
                        rechazo_s = 1'b1;
                    end else if (TeclaVal) begin
                        if (digito_ok_s) begin
                            clave_s      = {clave_r[CW-5:0], Tecla};
                            digitos_s    = 3'd1;
                            estado_s     = ST_CAPT;
                            tmr_cargar_s = 1'b1;
                            tmr_valor_s  = CARGA_INACT;
                        end else begin
                            rechazo_s = 1'b1;
                        end
                    end else begin
                        estado_s = ST_IDLE;
                    end
                end
                ST_CAPT: begin
                    if (TeclaBorr) begin
                        clave_s   = {CW{1'b0}};
                        digitos_s = 3'd0;
                        estado_s  = ST_IDLE;
                    end else if (TeclaEnt) begin
                        if (digitos_r == DIG_LLENO) begin
                            estado_s = ST_ENVIO;
                            enter_s  = 1'b1;
                        end else begin
                            rechazo_s = 1'b1;
                            clave_s   = {CW{1'b0}};
                            digitos_s = 3'd0;
                            estado_s  = ST_IDLE;
                        end
                    end else if (digito_ok_s && (digitos_r != DIG_LLENO)) begin
                        clave_s      = {clave_r[CW-5:0], Tecla};
                        digitos_s    = digitos_r + 3'd1;
                        tmr_cargar_s = 1'b1;
                        tmr_valor_s  = CARGA_INACT;
                    end else begin
                        // No accepted key: a refused digit still counts as idle time.
                        rechazo_s = TeclaVal;
                        if (tmr_exp_s) begin
                            rechazo_s = 1'b1;
                            clave_s   = {CW{1'b0}};
                            digitos_s = 3'd0;
                            estado_s  = ST_IDLE;
                        end else begin
                            tmr_decr_s = 1'b1;
                        end
                    end
                end
                ST_ENVIO: begin
                    estado_s     = ST_ESPERA;
                    tmr_cargar_s = 1'b1;
                    tmr_valor_s  = CARGA_RESP;
                end
                ST_ESPERA: begin
                    // Both verdict lines at once still end the attempt normally.
                    if (Abrir || AlrmInt) begin
                        clave_s   = {CW{1'b0}};
                        digitos_s = 3'd0;
                        estado_s  = ST_IDLE;
                    end else if (tmr_exp_s) begin
                        rechazo_s = 1'b1;
                        clave_s   = {CW{1'b0}};
                        digitos_s = 3'd0;
                        estado_s  = ST_IDLE;
                    end else begin
                        tmr_decr_s = 1'b1;
                    end
                end
                ST_BLOQ: begin
                    clave_s   = {CW{1'b0}};
                    digitos_s = 3'd0;
                    estado_s  = ST_IDLE;
                end
                default: begin
                    clave_s   = {CW{1'b0}};
                    digitos_s = 3'd0;
                    estado_s  = ST_IDLE;
                end
            endcase
        end

        ocupado_s = estado_ocupado(estado_s);
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            estado_r  <= ST_IDLE;
            clave_r   <= {CW{1'b0}};
            digitos_r <= 3'd0;
            enter_r   <= 1'b0;
            rechazo_r <= 1'b0;
            ocupado_r <= 1'b0;
        end else begin
            estado_r  <= estado_s;
            clave_r   <= clave_s;
            digitos_r <= digitos_s;
            enter_r   <= enter_s;
            rechazo_r <= rechazo_s;
            ocupado_r <= ocupado_s;
        end
    end

    assign Clave   = clave_r;
    assign Enter   = enter_r;
    assign Digitos = digitos_r;
    assign Rechazo = rechazo_r;
    assign Ocupado = ocupado_r;

endmodule

// File: tb/tb_secuenciador_teclado.sv
// Scoreboard bench for secuenciador_teclado: a behavioural model written in
// terms of a digit list and a few flags predicts the outputs after every edge;
// a monitor pops the prediction on each falling edge and compares.
module tb_secuenciador_teclado;

    localparam int N_DIG   = 4;
    localparam int T_INACT = 40;
    localparam int T_RESP  = 16;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Tecla = 4'd0;
    logic        TeclaVal = 1'b0;
    logic        TeclaEnt = 1'b0;
    logic        TeclaBorr = 1'b0;
    logic        Abrir = 1'b0;
    logic        AlrmInt = 1'b0;
    logic        AlrmCom = 1'b0;
    logic [15:0] Clave;
    logic        Enter;
    logic [2:0]  Digitos;
    logic        Rechazo;
    logic        Ocupado;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // expected {Clave, Enter, Digitos, Rechazo, Ocupado}
    logic [21:0] expq[$];

    // model state
    int dig[$];
    bit m_bloq, m_envio, m_espera;
    int m_resp, m_inact;

    secuenciador_teclado #(
        .N_DIG   (N_DIG),
        .T_INACT (T_INACT),
        .T_RESP  (T_RESP)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Tecla     (Tecla),
        .TeclaVal  (TeclaVal),
        .TeclaEnt  (TeclaEnt),
        .TeclaBorr (TeclaBorr),
        .Abrir     (Abrir),
        .AlrmInt   (AlrmInt),
        .AlrmCom   (AlrmCom),
        .Clave     (Clave),
        .Enter     (Enter),
        .Digitos   (Digitos),
        .Rechazo   (Rechazo),
        .Ocupado   (Ocupado)
    );

    initial forever #5 Clk = ~Clk;

    function automatic logic [15:0] clave_de();
        logic [15:0] v;
        v = 16'd0;
        foreach (dig[i]) v = v * 16'd16 + 16'(dig[i]);
        return v;
    endfunction

    task automatic model_reset();
        dig.delete();
        m_bloq = 1'b0; m_envio = 1'b0; m_espera = 1'b0;
        m_resp = 0; m_inact = 0;
        expq.delete();
        expq.push_back(22'd0);
    endtask

    // One clock edge of the reference behaviour, using the inputs held across it.
    task automatic model_step();
        bit rech;
        bit took;
        rech = 1'b0;
        took = 1'b0;
        if (!Reset) begin
            model_reset();
            return;
        end
        if (AlrmCom) begin
            m_bloq = 1'b1; m_envio = 1'b0; m_espera = 1'b0;
            dig.delete();
        end else if (m_bloq) begin
            m_bloq = 1'b0;
        end else if (m_envio) begin
            m_envio = 1'b0; m_espera = 1'b1; m_resp = T_RESP;
        end else if (m_espera) begin
            if (Abrir || AlrmInt) begin
                m_espera = 1'b0; dig.delete();
            end else begin
                m_resp--;
                if (m_resp == 0) begin
                    rech = 1'b1; m_espera = 1'b0; dig.delete();
                end
            end
        end else begin
            if (TeclaBorr) begin
                dig.delete();
            end else if (TeclaEnt) begin
                if (dig.size() == N_DIG) m_envio = 1'b1;
                else begin rech = 1'b1; dig.delete(); end
            end else if (TeclaVal) begin
                if (Tecla <= 4'd9 && dig.size() < N_DIG) begin
                    dig.push_back(int'(Tecla)); m_inact = 0; took = 1'b1;
                end else begin
                    rech = 1'b1;
                end
            end
            if (!took && !TeclaBorr && !TeclaEnt && dig.size() > 0) begin
                m_inact++;
                if (m_inact == T_INACT) begin rech = 1'b1; dig.delete(); end
            end
        end
        expq.push_back({clave_de(), m_envio, 3'(dig.size()), rech,
                        (m_bloq | m_envio | m_espera)});
    endtask

    // Advance one clock: model consumes the held inputs, then strobes drop.
    task automatic cycle();
        @(posedge Clk);
        model_step();
        #2;
        TeclaVal = 1'b0; TeclaEnt = 1'b0; TeclaBorr = 1'b0;
        Abrir = 1'b0; AlrmInt = 1'b0; AlrmCom = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        model_reset();
        started = 1'b1;
        #1;
        chk("reset_outputs", {10'd0, Clave, Enter, Digitos, Rechazo, Ocupado}, 32'd0);
        cycle();
        Reset = 1'b1;
    endtask

    task automatic key(input logic [3:0] d);
        Tecla = d; TeclaVal = 1'b1;
        cycle();
    endtask

    task automatic ent();
        TeclaEnt = 1'b1;
        cycle();
    endtask

    // Monitor: every falling edge the DUT presents registered outputs.
    initial forever begin
        logic [21:0] e;
        @(negedge Clk);
        if (started) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: no expectation queued at %0t", $time);
            end else begin
                e = expq.pop_front();
                if (e !== {Clave, Enter, Digitos, Rechazo, Ocupado}) begin
                    errors++;
                    $display("FAIL scoreboard: got clave=%h en=%b dig=%0d rech=%b ocup=%b expected clave=%h en=%b dig=%0d rech=%b ocup=%b at %0t",
                             Clave, Enter, Digitos, Rechazo, Ocupado,
                             e[21:6], e[5], e[4:2], e[1], e[0], $time);
                end
            end
        end
    end

    initial begin
        int r;
        int alrm_left;
        alrm_left = 0;
        #1;
        do_reset();

        // reset mid-capture
        key(4'd1); key(4'd2);
        chk("capt_digitos", 32'(Digitos), 32'd2);
        do_reset();

        // full password, enter, verdict
        key(4'd0); key(4'd2); key(4'd5); key(4'd9);
        ent();
        chk("enter_pulse", 32'(Enter), 32'd1);
        chk("enter_clave", 32'(Clave), 32'h0259);
        chk("enter_ocupado", 32'(Ocupado), 32'd1);
        cycle();
        chk("enter_one_cycle", 32'(Enter), 32'd0);
        Abrir = 1'b1;
        cycle();
        chk("abrir_digitos", 32'(Digitos), 32'd0);
        chk("abrir_ocupado", 32'(Ocupado), 32'd0);

        // short password then enter
        key(4'd0); key(4'd2); key(4'd5);
        ent();
        chk("short_rechazo", 32'(Rechazo), 32'd1);
        chk("short_no_enter", 32'(Enter), 32'd0);
        chk("short_clave", 32'(Clave), 32'd0);

        // non-BCD key and clear
        key(4'd1); key(4'hA);
        chk("nonbcd_rechazo", 32'(Rechazo), 32'd1);
        key(4'd2);
        chk("nonbcd_clave", 32'(Clave), 32'h0012);
        chk("nonbcd_digitos", 32'(Digitos), 32'd2);
        TeclaBorr = 1'b1; cycle();
        chk("borr_clave", 32'(Clave), 32'd0);

        // inactivity timeout
        key(4'd1); key(4'd2);
        repeat (T_INACT - 1) cycle();
        chk("inact_not_yet", 32'(Rechazo), 32'd0);
        cycle();
        chk("inact_rechazo", 32'(Rechazo), 32'd1);
        chk("inact_digitos", 32'(Digitos), 32'd0);

        // verdict timeout
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        ent(); cycle();
        repeat (T_RESP - 1) cycle();
        chk("resp_waiting", 32'({Ocupado, Rechazo}), 32'b10);
        cycle();
        chk("resp_timeout", 32'({Ocupado, Rechazo}), 32'b01);

        // alarm during capture
        key(4'd3);
        AlrmCom = 1'b1; cycle();
        chk("alarm_ocupado", 32'(Ocupado), 32'd1);
        chk("alarm_clave", 32'(Clave), 32'd0);
        AlrmCom = 1'b1; key(4'd5);
        chk("alarm_ignores_key", 32'(Digitos), 32'd0);
        cycle();
        chk("alarm_release", 32'(Ocupado), 32'd0);
        key(4'd7);
        chk("after_alarm_key", 32'({Clave, 13'd0, Digitos}), {16'h0007, 13'd0, 3'd1});

        // randomized traffic
        for (int c = 0; c < 6000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 3) TeclaBorr = 1'b1;
            else if (r < 11) TeclaEnt = 1'b1;
            else if (r < 50) begin
                TeclaVal = 1'b1;
                if ($urandom_range(0, 9) == 0) Tecla = 4'($urandom_range(10, 15));
                else Tecla = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 19) == 0) TeclaVal = 1'b1;
            Abrir   = ($urandom_range(0, 11) == 0);
            AlrmInt = ($urandom_range(0, 15) == 0);
            if (alrm_left > 0) begin
                AlrmCom = 1'b1; alrm_left--;
            end else if ($urandom_range(0, 299) == 0) begin
                alrm_left = $urandom_range(1, 5);
            end
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 249) == 0) begin
                TeclaVal = 1'b0; TeclaEnt = 1'b0; TeclaBorr = 1'b0;
                repeat (T_INACT + 2) cycle();
            end else begin
                cycle();
            end
        end

        repeat (3) cycle();
        @(negedge Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
